// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and
// sizing helpers derived from the operand width and chunk width.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int num_chunks(input int n, input int chunk);
        return n / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit index register.
    function automatic int idx_width(input int n, input int chunk);
        return ((n / chunk) > 1) ? $clog2(n / chunk) : 1;
    endfunction

endpackage

// File: rtl/seq_addsub_chunk_adder.sv
// W-bit ripple-carry adder assembled from per-bit full-adder cells.
module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement add/sub: N-bit operands go through one
// CHUNK-bit ripple adder, least-significant chunk first, with a carry register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for in_valid; operands captured on accept
// RUN     | one chunk processed per cycle, index counts up
// DONE    | result and flags valid, held until out_ready
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero
);

    localparam int NUM_CHUNKS = num_chunks(N, CHUNK);
    localparam int IW         = idx_width(N, CHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   result_q, result_d;
    logic           carry_out_q, carry_out_d;
    logic           overflow_q, overflow_d;
    logic           zero_q, zero_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             cout_chunk;

    // Constant-base selects keep the chunk mux free of variable part-selects.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_q == IW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.W(CHUNK)) u_chunk_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (sum_chunk),
        .cout (cout_chunk)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NUM_CHUNKS; i++) begin
                    if (idx_q == IW'(i)) begin
                        result_d[i*CHUNK +: CHUNK] = sum_chunk;
                    end
                end
                carry_d = cout_chunk;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    state_d     = ST_DONE;
                    carry_out_d = cout_chunk;
                    overflow_d  = (a_q[N-1] == b_q[N-1]) && (result_d[N-1] != a_q[N-1]);
                    zero_d      = (result_d == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed and randomised checks of seq_addsub in three configurations
// (32/8, 16/4, 32/32) sharing one stimulus bus.
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        sub;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;

    always #5 clk = ~clk;

    logic        in_ready0, out_valid0, co0, ov0, z0;
    logic [31:0] res0;
    logic        in_ready1, out_valid1, co1, ov1, z1;
    logic [15:0] res1;
    logic        in_ready2, out_valid2, co2, ov2, z2;
    logic [31:0] res2;

    seq_addsub #(.N(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid0),
        .out_ready(out_ready), .result(res0), .carry_out(co0),
        .overflow(ov0), .zero(z0)
    );

    seq_addsub #(.N(16), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .op_a(op_a[15:0]), .op_b(op_b[15:0]), .sub(sub), .out_valid(out_valid1),
        .out_ready(out_ready), .result(res1), .carry_out(co1),
        .overflow(ov1), .zero(z1)
    );

    seq_addsub #(.N(32), .CHUNK(32)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid2),
        .out_ready(out_ready), .result(res2), .carry_out(co2),
        .overflow(ov2), .zero(z2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: returns {zero, overflow, carry, result} for width w.
    function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        logic [31:0] mask, aa, bb, r;
        logic [63:0] sum;
        logic        c, v;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        aa   = a & mask;
        bb   = (s ? ~b : b) & mask;
        sum  = {32'b0, aa} + {32'b0, bb} + {63'b0, s};
        r    = sum[31:0] & mask;
        c    = sum[w];
        v    = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        return {(r == 32'h0), v, c, r};
    endfunction

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_r, input logic exp_c,
                         input logic exp_v, input logic exp_z);
        int cnt;
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid0 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, "_lat"}, 64'(cnt), 64'd4);
        chk({tag, "_res"}, {32'b0, res0}, {32'b0, exp_r});
        chk({tag, "_flags"}, {61'b0, co0, ov0, z0}, {61'b0, exp_c, exp_v, exp_z});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_release"}, {62'b0, out_valid0, in_ready0}, 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rdy_pat, vld_pat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", {25'b0, res0, in_ready0, out_valid0, co0, ov0, z0},
            {25'b0, 32'h0, 5'b10000});

        do_op("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        do_op("sub_3_5",   32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op("sub_5_3",   32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        do_op("sub_7_7",   32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Back-pressure, with operands changed while the op is in flight.
        op_a     = 32'h1234_5678;
        op_b     = 32'h1111_1111;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_a     = 32'hFFFF_FFFF;
        op_b     = 32'hFFFF_FFFF;
        sub      = 1'b1;
        for (int i = 0; i < 20 && !out_valid0; i++) tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", {30'b0, res0, out_valid0, in_ready0, co0, ov0, z0} >> 0,
                {30'b0, 32'h2345_6789, 5'b10000});
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {62'b0, out_valid0, in_ready0}, 64'b01);

        do_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Reset during the second RUN cycle; chunk 0 (0xAB) was already written.
        op_a     = 32'h0000_00AB;
        op_b     = 32'h0000_0000;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset", {25'b0, res0, in_ready0, out_valid0, co0, ov0, z0},
            {25'b0, 32'h0, 5'b10000});
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                seen = seen | out_valid0;
            end
            chk("no_valid_after_rst", {63'b0, seen}, 64'b0);
        end
        do_op("add_1_1",   32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

        // Back-to-back with out_ready tied high: period of six cycles.
        op_a      = 32'h0000_0010;
        op_b      = 32'h0000_0020;
        sub       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rdy_pat[k] = in_ready0;
            vld_pat[k] = out_valid0;
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_in_ready",  {52'b0, rdy_pat}, {52'b0, 12'h041});
        chk("b2b_out_valid", {52'b0, vld_pat}, {52'b0, 12'h820});
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;

        // Randomised runs across all three configurations.
        for (int t = 0; t < 20; t++) begin
            logic [31:0] ra, rb;
            logic        rs;
            int          l0, l1, l2;
            ra = $urandom();
            rb = $urandom();
            rs = 1'($urandom_range(0, 1));
            if (t == 0) begin ra = 32'h0000_8000; rb = 32'h0000_0001; rs = 1'b1; end
            if (t == 1) begin ra = 32'h0000_7FFF; rb = 32'h0000_7FFF; rs = 1'b0; end
            op_a     = ra;
            op_b     = rb;
            sub      = rs;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            l0 = -1; l1 = -1; l2 = -1;
            for (int c = 1; c <= 20 && (l0 < 0 || l1 < 0 || l2 < 0); c++) begin
                if (c > 1 || 1) tick();
                if (out_valid0 && l0 < 0) l0 = c;
                if (out_valid1 && l1 < 0) l1 = c;
                if (out_valid2 && l2 < 0) l2 = c;
            end
            chk("rnd_lat_32x8",  64'(l0), 64'd4);
            chk("rnd_lat_16x4",  64'(l1), 64'd4);
            chk("rnd_lat_32x32", 64'(l2), 64'd1);
            chk("rnd_32x8",  {29'b0, z0, ov0, co0, res0}, {29'b0, model(32, ra, rb, rs)});
            chk("rnd_16x4",  {29'b0, z1, ov1, co1, 16'h0, res1}, {29'b0, model(16, ra, rb, rs)});
            chk("rnd_32x32", {29'b0, z2, ov2, co2, res2}, {29'b0, model(32, ra, rb, rs)});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
